// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 32-bit combinational ALU: handshake, decode, operand fetch, writeback.
// Optional illegal-opcode trap (err + HALT) is enabled by defining ALU_SEQ_ILLEGAL_TRAP_EN.
module alu_sequencer #(
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr_data,
  input  logic              load_en,
  input  logic [REG_AW-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [31:0]       dbg_data,
  output logic [3:0]        alu_opsel,
  output logic              alu_muxsel,
  output logic [31:0]       alu_opa,
  output logic [31:0]       alu_opb,
  input  logic [31:0]       alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_equal,
  output logic              flag_carry,
  output logic              flag_overflow,
  output logic              flag_equal,
  output logic              done,
  output logic              err
);

  localparam int unsigned NREG = 1 << REG_AW;
  localparam int unsigned DW   = 32;
  localparam int unsigned OPW  = 4;
  localparam int unsigned RW   = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_DONE    = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   rf [NREG];
  logic [OPW-1:0]  op_q;
  logic            mux_q;
  logic [RW-1:0]   rd_q;
  logic [RW-1:0]   ra_q;
  logic [RW-1:0]   rb_q;
  logic            handshake_c;
  logic            legal_c;
  logic            writes_c;
  logic            unused_instr_c;

  assign unused_instr_c = ^instr_data[17:0];

  // Ready depends only on state and the preload strobe, never on instr_valid.
  assign instr_ready = (state == S_IDLE) & ~load_en;
  assign handshake_c = instr_valid & instr_ready;
  assign dbg_data    = rf[dbg_addr];

  always_comb begin
    legal_c = 1'b0;
    case (op_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b0110,
      4'b0111, 4'b1000, 4'b1001, 4'b1011: legal_c = 1'b1;
      default:                            legal_c = 1'b0;
    endcase
  end

  // NOP and (untrapped) illegal opcodes leave the register file and flags alone.
  assign writes_c = legal_c & (op_q != 4'b0000);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (handshake_c) state_nxt = S_DECODE;
      S_DECODE:  state_nxt = S_EXECUTE;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      S_EXECUTE: state_nxt = legal_c ? S_DONE : S_HALT;
`else
      S_EXECUTE: state_nxt = S_DONE;
`endif
      S_DONE:    state_nxt = S_IDLE;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Instruction latch, ALU operand registers, flags and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q          <= '0;
      mux_q         <= 1'b0;
      rd_q          <= '0;
      ra_q          <= '0;
      rb_q          <= '0;
      alu_opsel     <= '0;
      alu_muxsel    <= 1'b0;
      alu_opa       <= '0;
      alu_opb       <= '0;
      flag_carry    <= 1'b0;
      flag_overflow <= 1'b0;
      flag_equal    <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= (state_nxt == S_DONE);
      if (state == S_IDLE && handshake_c) begin
        op_q  <= instr_data[31:28];
        mux_q <= instr_data[27];
        rd_q  <= instr_data[26:24];
        ra_q  <= instr_data[23:21];
        rb_q  <= instr_data[20:18];
      end
      if (state == S_DECODE) begin
        alu_opsel  <= op_q;
        alu_muxsel <= mux_q;
        alu_opa    <= rf[REG_AW'(ra_q)];
        alu_opb    <= rf[REG_AW'(rb_q)];
      end
      if (state == S_EXECUTE && writes_c) begin
        flag_carry    <= alu_carry;
        flag_overflow <= alu_overflow;
        flag_equal    <= alu_equal;
      end
    end
  end

  // Register file: preload only in IDLE, writeback only in EXECUTE, so the ports never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else if (state == S_IDLE && load_en) begin
      rf[load_addr] <= load_data;
    end else if (state == S_EXECUTE && writes_c) begin
      rf[REG_AW'(rd_q)] <= alu_result;
    end
  end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)                                err <= 1'b0;
    else if (state == S_EXECUTE && !legal_c)  err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
